// File: rtl/rnn_env_pkg.sv
// Shared constants for the RNN environment responder: bank selects, FSM states, timeouts.
package rnn_env_pkg;

  localparam int DW            = 20;
  localparam int WAITB_TIMEOUT = 16;
  localparam int WAIT_W        = $clog2(WAITB_TIMEOUT);

  localparam logic [2:0] SEL_WIH  = 3'd0;
  localparam logic [2:0] SEL_BIH  = 3'd1;
  localparam logic [2:0] SEL_WHH  = 3'd2;
  localparam logic [2:0] SEL_BHH  = 3'd3;
  localparam logic [2:0] SEL_LEN  = 3'd4;
  localparam logic [2:0] SEL_OUT  = 3'd5;
  localparam logic [2:0] SEL_IN   = 3'd6;
  localparam logic [2:0] SEL_GOLD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAITB,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rnn_env_bank.sv
// Storage bank of 2**AW words: one synchronous write port, one asynchronous read port.
module rnn_env_bank
  import rnn_env_pkg::*;
#(
  parameter int AW = 6,
  parameter int W  = DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rnn_env_responder.sv
// Memory/stream responder for the RNN accelerator; host loads banks and reads OUT back.
// Define RNN_GOLDEN_CHECK_EN to add the GOLD bank and the mism_cnt output.
//
// state  | meaning
// IDLE   | host loads accepted, waiting for start
// ARM    | ready pulsed to accelerator
// WAITB  | waiting for busy, bounded by WAITB_TIMEOUT cycles
// RUN    | accelerator running, memory and stream served
// DONE   | done pulsed, back to IDLE
module rnn_env_responder
  import rnn_env_pkg::*;
#(
  parameter int T_MAX = 16,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [2:0]    ld_sel,
  input  logic [16:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic          i_en,
  output logic [31:0]   idata,
  input  logic          mce,
  input  logic [16:0]   maddr,
  input  logic [2:0]    msel,
  input  logic [DW-1:0] mdata_w,
  output logic [DW-1:0] mdata_r,
  input  logic [TW+5:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [TW+6:0] wr_cnt,
`ifdef RNN_GOLDEN_CHECK_EN
  output logic [TW+6:0] mism_cnt,
`endif
  output logic          proto_err
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TW:0]       in_ptr;
  logic [DW-1:0]     wih_q, bih_q, whh_q, bhh_q, len_q;
  logic [31:0]       in_q;
  logic              ld_ok, out_hit, out_wr, in_bad, err_now, launch;
  logic              unused_ld_addr;

  assign unused_ld_addr = ^ld_addr[16:12];
  assign ld_ok   = ld_en && (state == ST_IDLE);
  assign launch  = start && (state == ST_IDLE);
  assign out_hit = mce && (msel == SEL_OUT);
  assign out_wr  = out_hit && (maddr[16:TW+6] == '0);

  rnn_env_bank #(.AW(11)) u_wih (.clk(clk), .we(ld_ok && ld_sel == SEL_WIH),
    .waddr(ld_addr[10:0]), .wdata(ld_data[DW-1:0]), .raddr(maddr[10:0]), .rdata(wih_q));
  rnn_env_bank #(.AW(6)) u_bih (.clk(clk), .we(ld_ok && ld_sel == SEL_BIH),
    .waddr(ld_addr[5:0]), .wdata(ld_data[DW-1:0]), .raddr(maddr[5:0]), .rdata(bih_q));
  rnn_env_bank #(.AW(12)) u_whh (.clk(clk), .we(ld_ok && ld_sel == SEL_WHH),
    .waddr(ld_addr[11:0]), .wdata(ld_data[DW-1:0]), .raddr(maddr[11:0]), .rdata(whh_q));
  rnn_env_bank #(.AW(6)) u_bhh (.clk(clk), .we(ld_ok && ld_sel == SEL_BHH),
    .waddr(ld_addr[5:0]), .wdata(ld_data[DW-1:0]), .raddr(maddr[5:0]), .rdata(bhh_q));
  // LEN is a single word; only address 0 is ever written or read.
  rnn_env_bank #(.AW(1)) u_len (.clk(clk), .we(ld_ok && ld_sel == SEL_LEN && ld_addr == '0),
    .waddr(1'b0), .wdata(ld_data[DW-1:0]), .raddr(1'b0), .rdata(len_q));
  rnn_env_bank #(.AW(TW), .W(32)) u_in (.clk(clk), .we(ld_ok && ld_sel == SEL_IN),
    .waddr(ld_addr[TW-1:0]), .wdata(ld_data), .raddr(in_ptr[TW-1:0]), .rdata(in_q));
  rnn_env_bank #(.AW(TW+6)) u_out (.clk(clk), .we(out_wr),
    .waddr(maddr[TW+5:0]), .wdata(mdata_w), .raddr(rd_addr), .rdata(rd_data));

  always_comb begin
    mdata_r = '0;
    if (mce) begin
      case (msel)
        SEL_WIH: mdata_r = wih_q;
        SEL_BIH: mdata_r = bih_q;
        SEL_WHH: mdata_r = whh_q;
        SEL_BHH: mdata_r = bhh_q;
        SEL_LEN: if (maddr == '0) mdata_r = len_q;
        default: mdata_r = '0;
      endcase
    end
  end

  assign in_bad = (in_ptr == (TW+1)'(T_MAX)) || (DW'(in_ptr) > len_q);
  assign idata  = in_bad ? '0 : in_q;

  assign err_now = (i_en && in_bad)
                 || (mce && state != ST_RUN && state != ST_WAITB)
                 || (mce && msel[2:1] == 2'b11)
                 || (out_hit && !out_wr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      in_ptr    <= '0;
      wr_cnt    <= '0;
      ready     <= 1'b0;
      done      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ready <= 1'b0;
      done  <= 1'b0;
      if (err_now) proto_err <= 1'b1;
      if (out_wr) wr_cnt <= wr_cnt + (TW+7)'(1);
      if (i_en && state == ST_RUN && !in_bad) in_ptr <= in_ptr + (TW+1)'(1);
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_ARM;
          ready  <= 1'b1;
          wr_cnt <= '0;
          in_ptr <= '0;
        end
        ST_ARM: begin
          state    <= ST_WAITB;
          wait_cnt <= WAIT_W'(WAITB_TIMEOUT - 1);
        end
        ST_WAITB: begin
          if (busy) state <= ST_RUN;
          else if (wait_cnt == '0) begin
            state     <= ST_IDLE;
            proto_err <= 1'b1;
          end else wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_RUN: if (!busy) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RNN_GOLDEN_CHECK_EN
  logic [DW-1:0] gold_q;

  rnn_env_bank #(.AW(TW+6)) u_gold (.clk(clk), .we(ld_ok && ld_sel == SEL_GOLD),
    .waddr(ld_addr[TW+5:0]), .wdata(ld_data[DW-1:0]), .raddr(maddr[TW+5:0]), .rdata(gold_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mism_cnt <= '0;
    else if (launch) mism_cnt <= '0;
    else if (out_wr && mdata_w != gold_q) mism_cnt <= mism_cnt + (TW+7)'(1);
  end
`else
  logic unused_launch;
  assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_rnn_env_responder.sv
// Directed self-checking bench for rnn_env_responder.
module tb_rnn_env_responder;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_en = 1'b0;
  logic [2:0]    ld_sel = '0;
  logic [16:0]   ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          start = 1'b0;
  logic          ready;
  logic          busy = 1'b0;
  logic          i_en = 1'b0;
  logic [31:0]   idata;
  logic          mce = 1'b0;
  logic [16:0]   maddr = '0;
  logic [2:0]    msel = '0;
  logic [19:0]   mdata_w = '0;
  logic [19:0]   mdata_r;
  logic [TW+5:0] rd_addr = '0;
  logic [19:0]   rd_data;
  logic          done;
  logic [TW+6:0] wr_cnt;
  logic          proto_err;
`ifdef RNN_GOLDEN_CHECK_EN
  logic [TW+6:0] mism_cnt;
`endif

  int total = 0;
  int bad = 0;

  rnn_env_responder #(.T_MAX(16), .TW(TW)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .ready(ready), .busy(busy), .i_en(i_en),
    .idata(idata), .mce(mce), .maddr(maddr), .msel(msel), .mdata_w(mdata_w),
    .mdata_r(mdata_r), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .wr_cnt(wr_cnt),
`ifdef RNN_GOLDEN_CHECK_EN
    .mism_cnt(mism_cnt),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; busy = 1'b0; mce = 1'b0; i_en = 1'b0; start = 1'b0; ld_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [2:0] sel, input logic [16:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic go_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    busy = 1'b1;
    tick();
  endtask

  task automatic out_write(input logic [16:0] addr, input logic [19:0] data);
    mce = 1'b1; msel = 3'b101; maddr = addr; mdata_w = data;
    tick();
    mce = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", proto_err); end
    total++; if (wr_cnt !== '0) begin bad++; $display("FAIL reset_wrcnt got %0d want 0", wr_cnt); end
    total++; if (mdata_r !== '0) begin bad++; $display("FAIL reset_mdata got %h want 0", mdata_r); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mem_read();
    do_reset();
    load(3'b010, 17'h149, 32'h0000ABCD);
    load(3'b100, 17'h0, 32'd7);
    mce = 1'b1; msel = 3'b010; maddr = 17'h149;
    #1;
    total++; if (mdata_r !== 20'h0ABCD) begin bad++; $display("FAIL whh_read got %h want 0abcd", mdata_r); end
    msel = 3'b100; maddr = 17'h0;
    #1;
    total++; if (mdata_r !== 20'd7) begin bad++; $display("FAIL len_read got %h want 7", mdata_r); end
    maddr = 17'h1;
    #1;
    total++; if (mdata_r !== '0) begin bad++; $display("FAIL len_addr1 got %h want 0", mdata_r); end
    msel = 3'b010; maddr = 17'h149; mce = 1'b0;
    #1;
    total++; if (mdata_r !== '0) begin bad++; $display("FAIL mce_off got %h want 0", mdata_r); end
  endtask

  task automatic test_input_stream();
    do_reset();
    load(3'b100, 17'h0, 32'd2);
    load(3'b110, 17'h0, 32'h1);
    load(3'b110, 17'h1, 32'h2);
    // last load shares its edge with start
    ld_en = 1'b1; ld_sel = 3'b110; ld_addr = 17'h2; ld_data = 32'h3; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL arm_ready got %b want 1", ready); end
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_width got %b want 0", ready); end
    busy = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (idata !== 32'(k + 1)) begin bad++; $display("FAIL idata_%0d got %h want %h", k, idata, k + 1); end
      i_en = 1'b1;
      tick();
      i_en = 1'b0;
    end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL stream_err_early got %b want 0", proto_err); end
    total++; if (idata !== '0) begin bad++; $display("FAIL idata_past_len got %h want 0", idata); end
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL stream_overrun_err got %b want 1", proto_err); end
    busy = 1'b0;
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stream_done got %b want 1", done); end
  endtask

  task automatic test_waitb_timeout();
    int ready_seen;
    int done_seen;
    do_reset();
    ready_seen = 0;
    done_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (ready === 1'b1) ready_seen++;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (ready === 1'b1) ready_seen++;
      if (done === 1'b1) done_seen++;
      if (e == 16) begin
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL timeout_early got %b want 0", proto_err); end
      end
      if (e == 17) begin
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL timeout_err got %b want 1", proto_err); end
      end
    end
    total++; if (ready_seen != 1) begin bad++; $display("FAIL timeout_ready_pulses got %0d want 1", ready_seen); end
    total++; if (done_seen != 0) begin bad++; $display("FAIL timeout_done_pulses got %0d want 0", done_seen); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL timeout_back_idle got %b want 1", ready); end
  endtask

  task automatic test_out_writes();
    do_reset();
    go_run();
    for (int j = 0; j < 64; j++) out_write(17'(64 + j), 20'(j));
    total++; if (wr_cnt !== 11'd64) begin bad++; $display("FAIL wr_cnt_64 got %0d want 64", wr_cnt); end
    rd_addr = 10'h07F;
    #1;
    total++; if (rd_data !== 20'd63) begin bad++; $display("FAIL rd_1_63 got %h want 3f", rd_data); end
    rd_addr = 10'h060;
    #1;
    total++; if (rd_data !== 20'd32) begin bad++; $display("FAIL rd_1_32 got %h want 20", rd_data); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL run_err got %b want 0", proto_err); end
    out_write(17'h0, 20'h12345);
    total++; if (wr_cnt !== 11'd65) begin bad++; $display("FAIL wr_cnt_65 got %0d want 65", wr_cnt); end
    out_write(17'h10000, 20'h55555);
    total++; if (wr_cnt !== 11'd65) begin bad++; $display("FAIL bad_addr_wrcnt got %0d want 65", wr_cnt); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL bad_addr_err got %b want 1", proto_err); end
    rd_addr = 10'h000;
    #1;
    total++; if (rd_data !== 20'h12345) begin bad++; $display("FAIL bad_addr_dropped got %h want 12345", rd_data); end
    busy = 1'b0;
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL run_done got %b want 1", done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got %b want 0", done); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    go_run();
    out_write(17'h041, 20'h00ABC);
    total++; if (wr_cnt !== 11'd1) begin bad++; $display("FAIL mid_wrcnt got %0d want 1", wr_cnt); end
    reset = 1'b1;
    #2;
    total++; if (wr_cnt !== '0) begin bad++; $display("FAIL mid_reset_wrcnt got %0d want 0", wr_cnt); end
    tick();
    reset = 1'b0; busy = 1'b0;
    rd_addr = 10'h041;
    #1;
    total++; if (rd_data !== 20'h00ABC) begin bad++; $display("FAIL mid_reset_bank got %h want 00abc", rd_data); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_restart got %b want 1", ready); end
  endtask

`ifdef RNN_GOLDEN_CHECK_EN
  task automatic test_golden();
    do_reset();
    load(3'b111, 17'h3, 32'd5);
    go_run();
    total++; if (mism_cnt !== '0) begin bad++; $display("FAIL gold_start got %0d want 0", mism_cnt); end
    out_write(17'h3, 20'd6);
    total++; if (mism_cnt !== 11'd1) begin bad++; $display("FAIL gold_mismatch got %0d want 1", mism_cnt); end
    out_write(17'h3, 20'd5);
    total++; if (mism_cnt !== 11'd1) begin bad++; $display("FAIL gold_match got %0d want 1", mism_cnt); end
    busy = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_mem_read();
    test_input_stream();
    test_waitb_timeout();
    test_out_writes();
    test_reset_mid_run();
`ifdef RNN_GOLDEN_CHECK_EN
    test_golden();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
